// File: rtl/rr_mux_sequencer_if.sv
// Bundle between the round-robin sequencer, its downstream mux8x1 and the
// consumer of the captured data.
interface rr_mux_sequencer_if #(
    parameter int W = 8
);
    // req is a level: a channel keeps it high while it wants service.
    // out_valid/out_ready is a strict valid/ready pair: out_data and out_idx
    // are held stable while out_valid=1 and out_ready=0, a transfer happens on
    // the rising edge where both are 1, and out_ready is ignored while
    // out_valid=0.
    logic [7:0]   req;
    logic [W-1:0] mux_f;
    logic [2:0]   ctrl;
    logic [7:0]   ack;
    logic [W-1:0] out_data;
    logic [2:0]   out_idx;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic [1:0]   state_dbg;

    modport master (
        input  req, mux_f, out_ready,
        output ctrl, ack, out_data, out_idx, out_valid, busy, state_dbg
    );

    modport slave (
        output req, mux_f, out_ready,
        input  ctrl, ack, out_data, out_idx, out_valid, busy, state_dbg
    );
endinterface

// File: rtl/rr_mux_sequencer.sv
// Round-robin sequencer: picks a requesting channel, steers an external mux8x1
// to it, captures the mux output and presents it on a valid/ready port.
module rr_mux_sequencer #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_mux_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PRESENT = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   ctrl_q, ctrl_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [2:0]   out_idx_q, out_idx_d;

    logic         grant_found;
    logic [2:0]   grant_idx;
    logic [2:0]   probe_idx;

    // First requesting channel at or after ptr, wrapping modulo 8.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        probe_idx   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            probe_idx = ptr_q + 3'(i);
            if (!grant_found && bus.req[probe_idx]) begin
                grant_found = 1'b1;
                grant_idx   = probe_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            ctrl_q     <= 3'd0;
            out_data_q <= '0;
            out_idx_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ctrl_q     <= ctrl_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    // ctrl only moves on the IDLE->CAPTURE step so the mux select stays put
    // for the whole capture and presentation of that grant.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ctrl_d     = ctrl_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    ctrl_d  = grant_idx;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                out_data_d = bus.mux_f;
                out_idx_d  = ctrl_q;
                ptr_d      = ctrl_q + 3'd1;
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack       = (state_q == CAPTURE) ? (8'd1 << ctrl_q) : 8'd0;
        bus.out_valid = (state_q == PRESENT);
        bus.busy      = (state_q != IDLE);
        bus.ctrl      = ctrl_q;
        bus.out_data  = out_data_q;
        bus.out_idx   = out_idx_q;
        bus.state_dbg = state_q;
    end
endmodule

// File: tb/tb_rr_mux_sequencer.sv
// Bench for rr_mux_sequencer: directed scenarios plus random traffic, checked
// against a transaction-level round-robin model and an expected-data queue.
module tb_rr_mux_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   last_ack_cyc;

    rr_mux_sequencer_if #(.W(8)) bus();

    logic [7:0] mux_d [8];
    assign bus.mux_f = mux_d[bus.ctrl];

    rr_mux_sequencer #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model and scoreboard ----------------
    int         m_ptr;
    int         m_ctrl;
    logic [7:0] exp_q[$];

    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic mux_defaults();
        for (int i = 0; i < 8; i++) mux_d[i] = 8'h80 >> i;
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge.
    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"},  bus.ctrl, 0);
        check({tag, "_ack"},   bus.ack, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_data"},  bus.out_data, 0);
        check({tag, "_idx"},   bus.out_idx, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        m_ptr = 0;
        m_ctrl = 0;
        exp_q.delete();
    endtask

    task automatic idle_cycles(input int n);
        bus.req = 8'h00;
        repeat (n) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_busy",  bus.busy, 0);
            check("idle_valid", bus.out_valid, 0);
            check("idle_ack",   bus.ack, 0);
            check("idle_ctrl",  bus.ctrl, m_ctrl);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic grant_txn(input logic [7:0] r, input int stall,
                             input bit withdraw, input bit check_spacing);
        int         ch;
        int         waited;
        logic [7:0] exp_d;
        logic [7:0] hold_d;
        ch = rr_pick(r, m_ptr);
        bus.req = r;
        bus.out_ready = 1'($urandom_range(0, 1));
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.ack == 8'h00 && waited < 4);
        check("grant_seen", (bus.ack != 8'h00), 1);
        if (bus.ack == 8'h00) begin
            bus.req = 8'h00;
            return;
        end
        check("ack_onehot", bus.ack, 8'd1 << ch);
        check("ctrl_grant", bus.ctrl, ch);
        check("busy_cap",   bus.busy, 1);
        check("valid_cap",  bus.out_valid, 0);
        if (check_spacing) check("grant_spacing", cyc - last_ack_cyc, 3);
        last_ack_cyc = cyc;
        exp_q.push_back(mux_d[ch]);
        m_ptr  = (ch + 1) % 8;
        m_ctrl = ch;
        if (withdraw) bus.req = 8'h00;
        bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_d = exp_q.pop_front();
        check("valid_present", bus.out_valid, 1);
        check("idx_present",   bus.out_idx, ch);
        check("data_present",  bus.out_data, exp_d);
        check("ack_present",   bus.ack, 0);
        repeat (stall) begin
            bus.out_ready = 1'b0;
            hold_d = 8'($urandom);
            mux_d[$urandom_range(0, 7)] = hold_d;
            @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_data",  bus.out_data, exp_d);
            check("stall_idx",   bus.out_idx, ch);
            check("stall_ctrl",  bus.ctrl, ch);
            check("stall_ack",   bus.ack, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", bus.out_valid, 0);
        check("release_busy",  bus.busy, 0);
        bus.out_ready = 1'b0;
        bus.req = 8'h00;
    endtask

    // Reset pulsed between clock edges in CAPTURE or PRESENT.
    task automatic reset_mid(input bit in_present);
        int waited;
        bus.req = 8'hFF;
        bus.out_ready = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.ack == 8'h00 && waited < 4);
        check("mid_grant_seen", (bus.ack != 8'h00), 1);
        if (in_present) begin
            @(negedge clk);
            check("mid_valid_before", bus.out_valid, 1);
        end
        bus.req = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        check("mid_ack",   bus.ack, 0);
        check("mid_valid", bus.out_valid, 0);
        check("mid_ctrl",  bus.ctrl, 0);
        check("mid_busy",  bus.busy, 0);
        #1 rst_n = 1'b1;
        m_ptr = 0;
        m_ctrl = 0;
        exp_q.delete();
        @(negedge clk);
        check("mid_after_ack",   bus.ack, 0);
        check("mid_after_valid", bus.out_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        last_ack_cyc = 0;
        rst_n = 1'b0;
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        mux_defaults();
        @(negedge clk);
        do_reset();

        // single request on channel 3
        grant_txn(8'h08, 0, 1'b0, 1'b0);
        idle_cycles(3);

        // full sweep from a fresh reset, one grant every 3 cycles
        do_reset();
        for (int k = 0; k < 9; k++) grant_txn(8'hFF, 0, 1'b0, k > 0);

        // wrap-around search
        grant_txn(8'h40, 0, 1'b0, 1'b0);
        grant_txn(8'h41, 0, 1'b0, 1'b0);
        grant_txn(8'h41, 0, 1'b0, 1'b0);

        // back-pressure with the mux inputs changing underneath
        grant_txn(8'h02, 5, 1'b0, 1'b0);
        mux_defaults();

        // request withdrawn during CAPTURE
        grant_txn(8'h04, 1, 1'b1, 1'b0);
        idle_cycles(2);

        // reset mid-transaction, then search restarts at channel 0
        reset_mid(1'b1);
        grant_txn(8'hFF, 0, 1'b0, 1'b0);
        reset_mid(1'b0);
        grant_txn(8'hFF, 0, 1'b0, 1'b0);

        // random traffic
        for (int n = 0; n < 80; n++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            if (r == 8'h00) idle_cycles($urandom_range(1, 3));
            else grant_txn(r, $urandom_range(0, 3), $urandom_range(0, 3) == 0, 1'b0);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
